// File: rtl/div_pkg.sv
// Shared arithmetic definitions: adder width and the FSM state codes
// common to the divider and multiplier, so one top-level adder mux can decode both.
`default_nettype none
`ifndef DIV
`define DIV
package div_pkg;
    localparam int ADDER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        TRY  = 2'd2,
        INC  = 2'd3
    } state_t;
endpackage
`endif
`default_nettype wire

// File: rtl/div.sv
// Sequential unsigned restoring divider that borrows the shared adder for both
// the trial subtraction and the bit counter.
`default_nettype none
module div #(
    parameter int W       = 8,
    parameter int ADDER_W = div_pkg::ADDER_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       a_i,
    input  logic [W-1:0]       b_i,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [W-1:0]       quotient,
    output logic [W-1:0]       remainder,
    output logic [ADDER_W-1:0] sum_in_a,
    output logic [ADDER_W-1:0] sum_in_b,
    input  logic [ADDER_W-1:0] sum_out
);
    import div_pkg::*;

    localparam int CW = $clog2(W);

    state_t             state, state_nx;
    logic [W-1:0]       a, b, q;
    logic [ADDER_W-1:0] r, negb, s;
    logic [CW-1:0]      ctr;
    logic               q_bit;
    logic               last;
    logic               unused_r_msb;

    // The dividend register shifts left each trial, so its MSB is always the next bit.
    assign s            = {r[ADDER_W-2:0], a[W-1]};
    assign q_bit        = ~sum_out[ADDER_W-1];
    assign last         = (ctr == CW'(W-1));
    assign busy         = (state != IDLE);
    assign unused_r_msb = r[ADDER_W-1];

    always_comb begin
        state_nx = state;
        sum_in_a = '0;
        sum_in_b = '0;
        case (state)
            IDLE: begin
                if (start && (b_i != '0)) state_nx = NEG;
            end
            NEG: begin
                sum_in_a = ~{{(ADDER_W-W){1'b0}}, b};
                sum_in_b = ADDER_W'(1);
                state_nx = TRY;
            end
            TRY: begin
                sum_in_a = s;
                sum_in_b = negb;
                state_nx = last ? IDLE : INC;
            end
            INC: begin
                sum_in_a = ADDER_W'(ctr);
                sum_in_b = ADDER_W'(1);
                state_nx = TRY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            a           <= '0;
            b           <= '0;
            q           <= '0;
            r           <= '0;
            negb        <= '0;
            ctr         <= '0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b_i != '0) begin
                            a           <= a_i;
                            b           <= b_i;
                            r           <= '0;
                            q           <= '0;
                            ctr         <= '0;
                            div_by_zero <= 1'b0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= a_i;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                NEG: negb <= sum_out;
                TRY: begin
                    r <= q_bit ? sum_out : s;
                    q <= {q[W-2:0], q_bit};
                    a <= {a[W-2:0], 1'b0};
                    if (last) begin
                        quotient  <= {q[W-2:0], q_bit};
                        remainder <= q_bit ? sum_out[W-1:0] : s[W-1:0];
                        done      <= 1'b1;
                    end
                end
                INC: ctr <= sum_out[CW-1:0];
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_div.sv
// Directed self-checking bench for the sequential divider with a modelled shared adder.
`default_nettype none
module tb_div;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        busy, done, div_by_zero;
    logic [7:0]  quotient, remainder;
    logic [15:0] sum_in_a, sum_in_b, sum_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    assign sum_out = sum_in_a + sum_in_b;

    div dut (
        .clk(clk), .rst(rst), .a_i(a_i), .b_i(b_i), .start(start),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .quotient(quotient), .remainder(remainder),
        .sum_in_a(sum_in_a), .sum_in_b(sum_in_b), .sum_out(sum_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        a_i = av; b_i = bv; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // n counts edges after the accepting edge up to the edge that raises done.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL reset_flags: busy=%b done=%b dbz=%b expected 000", busy, done, div_by_zero); end
        tests++; if (quotient !== 8'd0 || remainder !== 8'd0) begin
            fails++; $display("FAIL reset_results: q=%0d r=%0d expected 0 0", quotient, remainder); end
        tests++; if (sum_in_a !== 16'd0 || sum_in_b !== 16'd0) begin
            fails++; $display("FAIL reset_adder: a=%0h b=%0h expected 0 0", sum_in_a, sum_in_b); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int n;
        launch(8'd200, 8'd7);
        tests++; if (busy !== 1'b1) begin
            fails++; $display("FAIL basic_busy: busy=%b expected 1", busy); end
        wait_done(n);
        tests++; if (n != 16) begin
            fails++; $display("FAIL basic_latency: got %0d expected 16", n); end
        tests++; if (busy !== 1'b0) begin
            fails++; $display("FAIL basic_busy_fall: busy=%b expected 0", busy); end
        tests++; if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin
            fails++; $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 28 4 0", quotient, remainder, div_by_zero); end
        tests++; if (sum_in_a !== 16'd0 || sum_in_b !== 16'd0) begin
            fails++; $display("FAIL basic_idle_adder: a=%0h b=%0h expected 0 0", sum_in_a, sum_in_b); end
        tick();
        tests++; if (done !== 1'b0 || quotient !== 8'd28) begin
            fails++; $display("FAIL basic_done_pulse: done=%b q=%0d expected 0 28", done, quotient); end
    endtask

    task automatic test_vectors();
        logic [7:0] av [3] = '{8'd255, 8'd5, 8'd255};
        logic [7:0] bv [3] = '{8'd1,   8'd9, 8'd255};
        logic [7:0] eq [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] er [3] = '{8'd0,   8'd5, 8'd0};
        int n;
        for (int i = 0; i < 3; i++) begin
            launch(av[i], bv[i]);
            wait_done(n);
            tests++; if (n != 16 || quotient !== eq[i] || remainder !== er[i]) begin
                fails++; $display("FAIL vector_%0d: n=%0d q=%0d r=%0d expected 16 %0d %0d", i, n, quotient, remainder, eq[i], er[i]); end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int n;
        launch(8'd13, 8'd0);
        tests++; if (busy !== 1'b0 || done !== 1'b1 || div_by_zero !== 1'b1) begin
            fails++; $display("FAIL dz_flags: busy=%b done=%b dbz=%b expected 0 1 1", busy, done, div_by_zero); end
        tests++; if (quotient !== 8'd255 || remainder !== 8'd13) begin
            fails++; $display("FAIL dz_result: q=%0d r=%0d expected 255 13", quotient, remainder); end
        tick();
        tests++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin
            fails++; $display("FAIL dz_hold: done=%b dbz=%b expected 0 1", done, div_by_zero); end
        launch(8'd13, 8'd4);
        tests++; if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL dz_clear: dbz=%b busy=%b expected 0 1", div_by_zero, busy); end
        wait_done(n);
        tests++; if (n != 16 || quotient !== 8'd3 || remainder !== 8'd1) begin
            fails++; $display("FAIL dz_next: n=%0d q=%0d r=%0d expected 16 3 1", n, quotient, remainder); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        launch(8'd100, 8'd3);
        n = 0;
        while (!done && n < 40) begin
            if (n == 4) begin a_i = 8'd9; b_i = 8'd9; start = 1'b1; end
            else if (n == 5) start = 1'b0;
            tick();
            n++;
        end
        tests++; if (n != 16 || quotient !== 8'd33 || remainder !== 8'd1) begin
            fails++; $display("FAIL ignored_start: n=%0d q=%0d r=%0d expected 16 33 1", n, quotient, remainder); end
        launch(8'd50, 8'd5);
        tests++; if (busy !== 1'b1) begin
            fails++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
        wait_done(n);
        tests++; if (n != 16 || quotient !== 8'd10 || remainder !== 8'd0) begin
            fails++; $display("FAIL b2b_result: n=%0d q=%0d r=%0d expected 16 10 0", n, quotient, remainder); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        int seen_done = 0;
        launch(8'd200, 8'd7);
        repeat (7) tick();
        rst = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || quotient !== 8'd0 || remainder !== 8'd0) begin
            fails++; $display("FAIL midreset_clear: busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
                busy, done, div_by_zero, quotient, remainder); end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen_done++;
        end
        tests++; if (seen_done != 0) begin
            fails++; $display("FAIL midreset_no_done: done pulses=%0d expected 0", seen_done); end
        rst = 1'b1;
        tick();
        launch(8'd17, 8'd5);
        wait_done(n);
        tests++; if (n != 16 || quotient !== 8'd3 || remainder !== 8'd2) begin
            fails++; $display("FAIL midreset_next: n=%0d q=%0d r=%0d expected 16 3 2", n, quotient, remainder); end
        tick();
    endtask

    task automatic test_idle_quiet();
        int bad = 0;
        a_i = 8'd77; b_i = 8'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy || sum_in_a != 16'd0 || sum_in_b != 16'd0) bad++;
        end
        tests++; if (bad != 0) begin
            fails++; $display("FAIL idle_quiet: noisy cycles=%0d expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_idle_quiet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
